// File: rtl/commit_pkg.sv
// Shared constants for the commit arbiter: arbitration modes, default widths
// and a pointer-width helper that stays legal for a depth of one.
package commit_pkg;

    localparam int unsigned ARB_FIXED  = 0;
    localparam int unsigned ARB_RR     = 1;

    localparam int unsigned DEF_NUM_CH = 6;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_RN_W   = 6;
    localparam int unsigned DEF_DEPTH  = 2;

    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// Per-channel result queue: circular buffer with modulo-DEPTH pointers and
// registered full/empty flags derived from the next-state count.
module commit_fifo
    import commit_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RN_W   = DEF_RN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [RN_W-1:0]   push_rn,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [RN_W-1:0]   head_rn_c,
    output logic [DATA_W-1:0] head_data_c
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [RN_W-1:0]   mem_rn   [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves the count untouched.
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is qualified by the pointers and count, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rn[wr_ptr_q]   <= push_rn;
            mem_data[wr_ptr_q] <= push_data;
        end
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign head_rn_c   = mem_rn[rd_ptr_q];
    assign head_data_c = mem_data[rd_ptr_q];

endmodule

// File: rtl/commit_arb.sv
// Result commit arbiter: per-channel queues feed a single register-file write
// port, granted by fixed priority or descending round-robin.
module commit_arb
    import commit_pkg::*;
#(
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned RN_W     = DEF_RN_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned ARB_MODE = ARB_FIXED
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*RN_W-1:0]   ch_rn,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_stall,
    output logic                     write_en,
    output logic [RN_W-1:0]          write_rn,
    output logic [DATA_W-1:0]        write_data
);

    localparam int unsigned IDX_W = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

    logic [NUM_CH-1:0] push_c;
    logic [NUM_CH-1:0] pop_c;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [RN_W-1:0]   head_rn   [NUM_CH];
    logic [DATA_W-1:0] head_data [NUM_CH];

    generate
        for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
            logic [RN_W-1:0] in_rn;
            assign in_rn = ch_rn[i*RN_W +: RN_W];
            // Writes to r0 are discarded at acceptance and never queued.
            assign push_c[i] = ch_valid[i] & ~full[i] & (in_rn != '0);

            commit_fifo #(
                .DEPTH  (DEPTH),
                .DATA_W (DATA_W),
                .RN_W   (RN_W)
            ) u_fifo (
                .clk         (clk),
                .rst_n       (rst_n),
                .push        (push_c[i]),
                .pop         (pop_c[i]),
                .push_rn     (in_rn),
                .push_data   (ch_data[i*DATA_W +: DATA_W]),
                .full        (full[i]),
                .empty       (empty[i]),
                .head_rn_c   (head_rn[i]),
                .head_data_c (head_data[i])
            );
        end
    endgenerate

    assign ch_stall = full;

    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  start_c;
    logic [IDX_W-1:0]  cand_idx_c;
    logic [IDX_W-1:0]  grant_idx_c;
    logic              found_c;
    int unsigned       cand_c;
    logic              write_en_q, write_en_d;
    logic [RN_W-1:0]   write_rn_q, write_rn_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    // Descending search from start_c; fixed priority always starts at the top.
    always_comb begin
        start_c      = (ARB_MODE == ARB_RR) ? rr_q : LAST_CH;
        found_c      = 1'b0;
        grant_idx_c  = '0;
        cand_c       = 0;
        cand_idx_c   = '0;
        pop_c        = '0;
        rr_d         = rr_q;
        write_en_d   = 1'b0;
        write_rn_d   = '0;
        write_data_d = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand_c     = (32'(start_c) + NUM_CH - k) % NUM_CH;
            cand_idx_c = IDX_W'(cand_c);
            if (!found_c && !empty[cand_idx_c]) begin
                found_c     = 1'b1;
                grant_idx_c = cand_idx_c;
            end
        end
        if (found_c) begin
            pop_c[grant_idx_c] = 1'b1;
            rr_d               = (grant_idx_c == '0) ? LAST_CH : grant_idx_c - IDX_W'(1);
            write_en_d         = 1'b1;
            write_rn_d         = head_rn[grant_idx_c];
            write_data_d       = head_data[grant_idx_c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= LAST_CH;
            write_en_q   <= 1'b0;
            write_rn_q   <= '0;
            write_data_q <= '0;
        end else begin
            rr_q         <= rr_d;
            write_en_q   <= write_en_d;
            write_rn_q   <= write_rn_d;
            write_data_q <= write_data_d;
        end
    end

    assign write_en   = write_en_q;
    assign write_rn   = write_rn_q;
    assign write_data = write_data_q;

endmodule

// File: doc/commit_arb.md
COMMIT_ARB -- requirements
Module: commit_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 6: number of execution-unit result channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 64: result data width.
REQ-003 SHALL have parameter RN_W, default 6: destination register number width.
REQ-004 SHALL have parameter DEPTH, default 2: per-channel result queue depth (1..8).
REQ-005 SHALL have parameter ARB_MODE, default 0: 0 = fixed priority, 1 = round-robin.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port ch_valid  input  NUM_CH  per-channel result offered.
REQ-009 SHALL have port ch_rn  input  NUM_CH*RN_W  per-channel destination register; channel i occupies bits [i*RN_W +: RN_W].
REQ-010 SHALL have port ch_data  input  NUM_CH*DATA_W  per-channel result; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port ch_stall  output  NUM_CH  per-channel back-pressure.
REQ-012 SHALL have port write_en  output  1  register-file write strobe.
REQ-013 SHALL have port write_rn  output  RN_W  register-file write address.
REQ-014 SHALL have port write_data  output  DATA_W  register-file write data.

Function
REQ-015 ch_stall[i] SHALL be 1 exactly when channel i's queue holds DEPTH entries (registered count, no same-cycle pop bypass).
REQ-016 Channel i SHALL accept a result on a rising edge where ch_valid[i]=1 and ch_stall[i]=0; a stalled producer holds valid, rn and data until accepted.
REQ-017 An accepted result with rn=0 SHALL be dropped (not enqueued, never written); r0 is never written.
REQ-018 Each queue SHALL be FIFO; results from one channel are written in acceptance order.
REQ-019 Each cycle the arbiter SHALL grant at most one non-empty queue, pop its head and register it onto write_en/write_rn/write_data.
REQ-020 Latency: a result accepted at edge E into an empty queue, if granted, SHALL appear with write_en=1 after edge E+1; it is never visible the cycle it is accepted.
REQ-021 ARB_MODE=0: highest-indexed non-empty queue SHALL win.
REQ-022 ARB_MODE=1: search SHALL start one index below the last granted channel, descending with wrap from 0 to NUM_CH-1; after reset, search starts at NUM_CH-1.
REQ-023 write_en SHALL be high for exactly one cycle per written result; when write_en=0, write_rn and write_data SHALL be 0.
REQ-024 Simultaneous push and pop on one queue SHALL leave its count unchanged and preserve order; a push to a full queue cannot occur (stall).
REQ-025 All channels offering in the same cycle SHALL all be accepted if not stalled; none lost.
REQ-026 Queue pointers SHALL wrap modulo DEPTH; non-power-of-two DEPTH SHALL be supported.

Reset
REQ-027 On rst_n low, all queues SHALL empty immediately: ch_stall=0, write_en=0, write_rn=0, write_data=0, round-robin pointer = NUM_CH-1.
REQ-028 Reset mid-operation SHALL discard all queued results; none are written after release.
REQ-029 Queue data storage SHALL NOT require reset.

Structure
REQ-030 A shared package commit_pkg SHALL hold ARB_MODE constants (ARB_FIXED=0, ARB_RR=1) and default widths.
REQ-031 A per-channel sub-module commit_fifo (push, pop, full, empty, head rn/data) SHALL be instantiated NUM_CH times via generate.
REQ-032 Arbiter and output register SHALL reside in commit_arb.

Verification
REQ-033 Defaults, ch_valid[0]=1 one cycle, rn=5, data=0xAA -> write_en=1, write_rn=5, write_data=0xAA exactly one cycle, two edges after offer.
REQ-034 ARB_MODE=0, all six channels offer once, rn=i+1 -> six writes, rn order 6,5,4,3,2,1 on consecutive cycles.
REQ-035 DEPTH=2, channel 0 held valid 4 cycles with rn 1..4 while channel 5 continuously offers -> ch_stall[0]=1 once full; channel 0 writes 1..4 in order after channel 5 stops.
REQ-036 ARB_MODE=1, channels 5 and 1 continuously supplied -> writes alternate 5,1,5,1.
REQ-037 Offer rn=0 on channel 2 -> no write_en pulse, ch_stall[2] stays 0.
REQ-038 Fill three queues, assert rst_n low one cycle mid-drain -> outputs 0 immediately; no further write_en after release.
